softmax_vec: RTL and testbench

Parametrised fixed-point softmax over one LANES-wide vector per transaction, successor to the fixed 16×8-bit `Softmax`. Accepts a vector on a ready/valid input and computes a base-2 softmax with max-subtraction, LUT exponent, lane sum, sequential reciprocal and per-lane multiply. It returns LANES probabilities on a ready/valid output with `last` forwarded. Sits between the score datapath and the output quantiser; upstream pre-scales scores by log2(e).

---
 rtl/softmax_vec.sv | 204 ++++++++++++++++++++
 tb/tb_softmax_vec.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/softmax_vec.sv
// Base-2 fixed-point softmax over one LANES vector; result valid OUT_W+5 cycles after input fire.
// Output stalls in OUT until io_output_ready; input ready only when idle or draining. Optional lane mask: SOFTMAX_MASK_EN.
module softmax_vec #(
    parameter int LANES = 16,
    parameter int IN_W  = 8,
    parameter int FRAC  = 4,
    parameter int E_W   = 16,
    parameter int OUT_W = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   io_input_valid,
    output logic                   io_input_ready,
    input  logic [LANES*IN_W-1:0]  io_input_bits_in,
    input  logic                   io_input_bits_last,
`ifdef SOFTMAX_MASK_EN
    input  logic [LANES-1:0]       io_input_bits_mask,
`endif
    output logic                   io_output_valid,
    input  logic                   io_output_ready,
    output logic [LANES*OUT_W-1:0] io_output_bits_out,
    output logic                   io_output_bits_last
);

    localparam int SW   = E_W + $clog2(LANES);
    localparam int QW   = OUT_W + 1;
    localparam int CW   = $clog2(QW);
    localparam int PW   = E_W + QW;
    localparam int NLUT = 1 << FRAC;
    // Dividend is 2^(E_W+OUT_W); its bits above the quotient window seed the remainder.
    localparam logic [SW:0] REM_INIT = {{(SW+1-E_W){1'b0}}, 1'b1, {(E_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MAX, S_EXP, S_SUM, S_DIV, S_MUL, S_OUT} state_t;

    state_t state_q, state_d;

    logic [LANES*IN_W-1:0]  x_q;
    logic                   last_q;
    logic signed [IN_W-1:0] m_q;
    logic [E_W-1:0]         e_q [LANES];
    logic [SW-1:0]          s_q;
    logic [SW:0]            rem_q;
    logic [QW-1:0]          q_q;
    logic [CW-1:0]          cnt_q;
    logic [LANES*OUT_W-1:0] out_dat_q;
    logic                   out_last_q;
    logic                   out_vld_q;
    logic [LANES-1:0]       lane_en;

    logic                   in_fire;
    logic signed [IN_W-1:0] max_c;
    logic [IN_W-1:0]        d_c;
    logic [IN_W-1:0]        k_c;
    logic [FRAC-1:0]        f_c;
    logic [E_W-1:0]         e_c [LANES];
    logic [SW-1:0]          s_c;
    logic [SW:0]            rem_sh;
    logic                   ge;
    logic [QW-1:0]          hi_c;
    logic [LANES*OUT_W-1:0] p_c;

    function automatic int lut_entry(input int f);
        real v;
        v = ((2.0 ** E_W) - 1.0) * (2.0 ** (-real'(f) / real'(NLUT)));
        return $rtoi($floor(v));
    endfunction

    logic [E_W-1:0] lut [NLUT];
    for (genvar g = 0; g < NLUT; g++) begin : g_lut
        assign lut[g] = E_W'(lut_entry(g));
    end

`ifdef SOFTMAX_MASK_EN
    logic [LANES-1:0] mask_q;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mask_q <= '0;
        end else if (in_fire) begin
            mask_q <= io_input_bits_mask;
        end
    end
    assign lane_en = mask_q;
`else
    assign lane_en = '1;
`endif

    assign io_input_ready      = (state_q == S_IDLE) || (state_q == S_OUT && io_output_ready);
    assign in_fire             = io_input_valid && io_input_ready;
    assign io_output_valid     = out_vld_q;
    assign io_output_bits_out  = out_dat_q;
    assign io_output_bits_last = out_last_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_fire) state_d = S_MAX;
            S_MAX:   state_d = S_EXP;
            S_EXP:   state_d = S_SUM;
            S_SUM:   state_d = S_DIV;
            S_DIV:   if (cnt_q == CW'(OUT_W)) state_d = S_MUL;
            S_MUL:   state_d = S_OUT;
            S_OUT:   if (io_output_ready) state_d = in_fire ? S_MAX : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Masked lanes start from the most negative value so they never win the max.
    always_comb begin
        max_c = {1'b1, {(IN_W-1){1'b0}}};
        for (int i = 0; i < LANES; i++) begin
            if (lane_en[i] && $signed(x_q[i*IN_W +: IN_W]) > max_c) begin
                max_c = $signed(x_q[i*IN_W +: IN_W]);
            end
        end
    end

    always_comb begin
        d_c = '0;
        k_c = '0;
        f_c = '0;
        for (int i = 0; i < LANES; i++) begin
            d_c = m_q - x_q[i*IN_W +: IN_W];
            k_c = d_c >> FRAC;
            f_c = d_c[FRAC-1:0];
            if (!lane_en[i] || int'(k_c) >= E_W) begin
                e_c[i] = '0;
            end else begin
                e_c[i] = lut[f_c] >> k_c;
            end
        end
    end

    always_comb begin
        s_c = '0;
        for (int i = 0; i < LANES; i++) begin
            s_c = s_c + SW'(e_q[i]);
        end
    end

    // A zero sum only arises with every lane masked; suppress quotient bits so R stays 0.
    assign rem_sh = {rem_q[SW-1:0], 1'b0};
    assign ge     = (s_q != '0) && (rem_sh >= {1'b0, s_q});

    always_comb begin
        hi_c = '0;
        p_c  = '0;
        for (int i = 0; i < LANES; i++) begin
            hi_c = QW'(({{QW{1'b0}}, e_q[i]} * {{E_W{1'b0}}, q_q}) >> E_W);
            p_c[i*OUT_W +: OUT_W] = hi_c[OUT_W] ? {OUT_W{1'b1}} : hi_c[OUT_W-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_q        <= '0;
            last_q     <= 1'b0;
            m_q        <= '0;
            for (int i = 0; i < LANES; i++) e_q[i] <= '0;
            s_q        <= '0;
            rem_q      <= '0;
            q_q        <= '0;
            cnt_q      <= '0;
            out_dat_q  <= '0;
            out_last_q <= 1'b0;
            out_vld_q  <= 1'b0;
        end else begin
            if (in_fire) begin
                x_q    <= io_input_bits_in;
                last_q <= io_input_bits_last;
            end
            case (state_q)
                S_MAX: m_q <= max_c;
                S_EXP: for (int i = 0; i < LANES; i++) e_q[i] <= e_c[i];
                S_SUM: begin
                    s_q   <= s_c;
                    rem_q <= REM_INIT;
                    q_q   <= '0;
                    cnt_q <= '0;
                end
                S_DIV: begin
                    rem_q <= ge ? (rem_sh - {1'b0, s_q}) : rem_sh;
                    q_q   <= {q_q[QW-2:0], ge};
                    cnt_q <= cnt_q + CW'(1);
                end
                S_MUL: begin
                    out_dat_q  <= p_c;
                    out_last_q <= last_q;
                    out_vld_q  <= 1'b1;
                end
                S_OUT: if (io_output_ready) out_vld_q <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_vec.sv
// Directed-vector bench for softmax_vec at default parameters; expected outputs are hand-computed.
module tb_softmax_vec;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         io_input_valid = 1'b0;
    logic         io_input_ready;
    logic [127:0] io_input_bits_in = '0;
    logic         io_input_bits_last = 1'b0;
`ifdef SOFTMAX_MASK_EN
    logic [15:0]  io_input_bits_mask = 16'hFFFF;
`endif
    logic         io_output_valid;
    logic         io_output_ready = 1'b0;
    logic [127:0] io_output_bits_out;
    logic         io_output_bits_last;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] V1 = {16{8'h10}};
    localparam logic [127:0] E1 = {16{8'h0F}};
    localparam logic [127:0] V2 = 128'h30303030_20202020_10101010_00000000;
    localparam logic [127:0] E2 = 128'h21212121_10101010_08080808_04040404;
    localparam logic [127:0] V3 = 128'h80808080_80808080_80807F80_80808080;
    localparam logic [127:0] E3 = 128'h00000000_00000000_0000FE00_00000000;

    softmax_vec dut (
        .clock               (clock),
        .reset               (reset),
        .io_input_valid      (io_input_valid),
        .io_input_ready      (io_input_ready),
        .io_input_bits_in    (io_input_bits_in),
        .io_input_bits_last  (io_input_bits_last),
`ifdef SOFTMAX_MASK_EN
        .io_input_bits_mask  (io_input_bits_mask),
`endif
        .io_output_valid     (io_output_valid),
        .io_output_ready     (io_output_ready),
        .io_output_bits_out  (io_output_bits_out),
        .io_output_bits_last (io_output_bits_last)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input string tag, input logic [127:0] v, input logic l);
        int n;
        @(negedge clock);
        io_input_bits_in   = v;
        io_input_bits_last = l;
        io_input_valid     = 1'b1;
        n = 0;
        while (!io_input_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        check({tag, " accept"}, 128'(io_input_ready), 128'(1));
        @(posedge clock);
        #1;
        io_input_valid = 1'b0;
    endtask

    // Called 1 time unit after the input-fire edge; counts edges until valid.
    task automatic wait_result(input string tag);
        int cyc;
        cyc = 0;
        do begin
            @(posedge clock);
            #1;
            cyc++;
        end while (!io_output_valid && cyc < 40);
        check({tag, " latency"}, 128'(cyc), 128'(13));
    endtask

    task automatic check_lanes(input string tag, input logic [127:0] exp);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s lane%0d", tag, i), 128'(io_output_bits_out[i*8 +: 8]), 128'(exp[i*8 +: 8]));
        end
    endtask

    task automatic recv(input string tag, input logic [127:0] exp, input logic l);
        wait_result(tag);
        check_lanes(tag, exp);
        check({tag, " last"}, 128'(io_output_bits_last), 128'(l));
        @(negedge clock);
        io_output_ready = 1'b1;
        @(posedge clock);
        #1;
        io_output_ready = 1'b0;
        check({tag, " valid drop"}, 128'(io_output_valid), 128'(0));
    endtask

    initial begin
        #3 reset = 1'b0;
        #1;
        check("rst valid", 128'(io_output_valid), 128'(0));
        check("rst out", io_output_bits_out, 128'(0));
        check("rst last", 128'(io_output_bits_last), 128'(0));
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst ready", 128'(io_input_ready), 128'(1));

        send("t1", V1, 1'b1);
        recv("t1", E1, 1'b1);
        send("t2", V2, 1'b0);
        recv("t2", E2, 1'b0);
        send("t3", V3, 1'b1);
        recv("t3", E3, 1'b1);

        // Backpressure: hold the result, offer the next vector, then fire both together.
        send("bp", V1, 1'b1);
        wait_result("bp");
        @(negedge clock);
        io_input_bits_in   = V2;
        io_input_bits_last = 1'b0;
        io_input_valid     = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check($sformatf("bp hold%0d data", c), io_output_bits_out, E1);
            check($sformatf("bp hold%0d valid", c), 128'(io_output_valid), 128'(1));
            check($sformatf("bp hold%0d in_rdy", c), 128'(io_input_ready), 128'(0));
        end
        io_output_ready = 1'b1;
        #1;
        check("bp joint in_rdy", 128'(io_input_ready), 128'(1));
        check("bp last held", 128'(io_output_bits_last), 128'(1));
        @(posedge clock);
        #1;
        io_output_ready = 1'b0;
        io_input_valid  = 1'b0;
        check("bp valid after fire", 128'(io_output_valid), 128'(0));
        recv("bp2", E2, 1'b0);

        // Reset while the divider is running.
        send("rd", V1, 1'b1);
        repeat (5) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("rd valid", 128'(io_output_valid), 128'(0));
        check("rd out", io_output_bits_out, 128'(0));
        check("rd in_rdy", 128'(io_input_ready), 128'(1));
        @(negedge clock);
        reset = 1'b1;
        send("rd2", V3, 1'b1);
        recv("rd2", E3, 1'b1);

`ifdef SOFTMAX_MASK_EN
        io_input_bits_mask = 16'h0FFF;
        send("mk", V2, 1'b0);
        recv("mk", 128'h00000000_23232323_11111111_08080808, 1'b0);
        io_input_bits_mask = 16'h0000;
        send("mk0", V2, 1'b1);
        recv("mk0", 128'(0), 1'b1);
        io_input_bits_mask = 16'hFFFF;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
